time_sequencer: RTL and testbench

TIME_SEQUENCER -- requirements
Module: time_sequencer

---
 rtl/time_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_time_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_sequencer.sv
// Clock time sequencer: sequences sec/min/hour updates through an
// external 6-bit ALU, with a set mode for incrementing and decrementing fields.
module time_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       set_mode,
  input  logic [1:0] set_field,
  input  logic       set_inc,
  input  logic       set_dec,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [1:0] alu_s,
  output logic       alu_cin,
  input  logic [5:0] alu_data,
  input  logic       alu_cout,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic       day_carry,
  output logic       busy,
  output logic       tick_overrun
);

  typedef enum logic [2:0] {
    IDLE, SEC, MIN, HR, EDIT
  } state_t;

  localparam logic [1:0] F_SEC = 2'b00;
  localparam logic [1:0] F_MIN = 2'b01;
  localparam logic [1:0] F_HR  = 2'b10;
  localparam logic [1:0] F_NONE = 2'b11;

  localparam logic [1:0] S_INC = 2'b10;
  localparam logic [1:0] S_DEC = 2'b11;

  state_t     r_state;
  logic       r_pending;
  logic       r_dec;
  logic [1:0] r_fld;

  logic       w_tick_ok;
  logic       w_edit_req;
  logic       w_ge60;
  logic       w_ge24;
  logic [5:0] w_sel_val;
  logic [5:0] w_fld_val;
  logic [5:0] w_max;
  logic       w_wrap;
  logic [5:0] w_edit_val;
  logic       w_unused;

  // Wrap detection uses range compares on the result only
  assign w_unused = alu_cout;

  assign w_tick_ok  = tick_1hz & ~set_mode;
  assign w_edit_req = set_mode & (set_inc ^ set_dec)
                    & (set_field != F_NONE);
  assign w_ge60 = (alu_data >= 6'd60);
  assign w_ge24 = (alu_data >= 6'd24);

  always_comb begin
    w_sel_val = sec;
    case (set_field)
      F_MIN:   w_sel_val = min;
      F_HR:    w_sel_val = hour;
      default: w_sel_val = sec;
    endcase
  end

  always_comb begin
    w_fld_val = sec;
    w_max     = 6'd59;
    w_wrap    = w_ge60;
    case (r_fld)
      F_MIN: w_fld_val = min;
      F_HR: begin
        w_fld_val = hour;
        w_max     = 6'd23;
        w_wrap    = w_ge24;
      end
      default: w_fld_val = sec;
    endcase
  end

  // Decrement of zero loads the field maximum directly
  always_comb begin
    w_edit_val = alu_data;
    if (r_dec && (w_fld_val == 6'd0))
      w_edit_val = w_max;
    else if (w_wrap)
      w_edit_val = 6'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pending    <= 1'b0;
      r_dec        <= 1'b0;
      r_fld        <= F_SEC;
      sec          <= 6'd0;
      min          <= 6'd0;
      hour         <= 6'd0;
      day_carry    <= 1'b0;
      busy         <= 1'b0;
      tick_overrun <= 1'b0;
      alu_a        <= 6'd0;
      alu_b        <= 6'd0;
      alu_s        <= 2'b00;
      alu_cin      <= 1'b0;
    end else begin
      day_carry <= 1'b0;
      if ((r_state != IDLE) && w_tick_ok) begin
        if (r_pending)
          tick_overrun <= 1'b1;
        else
          r_pending <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (!set_mode && (tick_1hz || r_pending)) begin
            if (tick_1hz && r_pending)
              tick_overrun <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= SEC;
            busy      <= 1'b1;
            alu_a     <= sec;
            alu_b     <= 6'd0;
            alu_s     <= S_INC;
            alu_cin   <= 1'b1;
          end else if (w_edit_req) begin
            r_state <= EDIT;
            busy    <= 1'b1;
            r_fld   <= set_field;
            r_dec   <= set_dec;
            alu_a   <= w_sel_val;
            alu_b   <= 6'd0;
            alu_s   <= set_dec ? S_DEC : S_INC;
            alu_cin <= ~set_dec;
          end
        end
        SEC: begin
          if (w_ge60) begin
            sec     <= 6'd0;
            r_state <= MIN;
            alu_a   <= min;
          end else begin
            sec     <= alu_data;
            r_state <= IDLE;
            busy    <= 1'b0;
            alu_a   <= 6'd0;
            alu_s   <= 2'b00;
            alu_cin <= 1'b0;
          end
        end
        MIN: begin
          if (w_ge60) begin
            min     <= 6'd0;
            r_state <= HR;
            alu_a   <= hour;
          end else begin
            min     <= alu_data;
            r_state <= IDLE;
            busy    <= 1'b0;
            alu_a   <= 6'd0;
            alu_s   <= 2'b00;
            alu_cin <= 1'b0;
          end
        end
        HR: begin
          if (w_ge24) begin
            hour      <= 6'd0;
            day_carry <= 1'b1;
          end else begin
            hour <= alu_data;
          end
          r_state <= IDLE;
          busy    <= 1'b0;
          alu_a   <= 6'd0;
          alu_s   <= 2'b00;
          alu_cin <= 1'b0;
        end
        EDIT: begin
          case (r_fld)
            F_MIN:   min  <= w_edit_val;
            F_HR:    hour <= w_edit_val;
            default: sec  <= w_edit_val;
          endcase
          r_state <= IDLE;
          busy    <= 1'b0;
          alu_a   <= 6'd0;
          alu_s   <= 2'b00;
          alu_cin <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_sequencer.sv
// Directed bench for time_sequencer with a behavioural 6-bit ALU
// answering the sequencer's operand requests.
module tb_time_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       set_mode;
  logic [1:0] set_field;
  logic       set_inc;
  logic       set_dec;
  logic [5:0] alu_a;
  logic [5:0] alu_b;
  logic [1:0] alu_s;
  logic       alu_cin;
  logic [5:0] alu_data;
  logic       alu_cout;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hour;
  logic       day_carry;
  logic       busy;
  logic       tick_overrun;

  logic [6:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    sum = 7'd0;
    case (alu_s)
      2'b00: sum = {1'b0, alu_a} + {1'b0, alu_b} + {6'd0, alu_cin};
      2'b01: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {6'd0, alu_cin};
      2'b10: sum = {1'b0, alu_a} + {6'd0, alu_cin};
      default: sum = {1'b0, alu_a} + 7'h3F + {6'd0, alu_cin};
    endcase
  end
  assign alu_data = sum[5:0];
  assign alu_cout = sum[6];

  time_sequencer dut (
    .clk(clk),
    .reset(reset),
    .tick_1hz(tick_1hz),
    .set_mode(set_mode),
    .set_field(set_field),
    .set_inc(set_inc),
    .set_dec(set_dec),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_s(alu_s),
    .alu_cin(alu_cin),
    .alu_data(alu_data),
    .alu_cout(alu_cout),
    .sec(sec),
    .min(min),
    .hour(hour),
    .day_carry(day_carry),
    .busy(busy),
    .tick_overrun(tick_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic edit(input logic [1:0] f, input logic inc,
                      input logic dec);
    set_field = f;
    set_inc   = inc;
    set_dec   = dec;
    step();
    set_inc = 1'b0;
    set_dec = 1'b0;
    step();
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    tick_1hz  = 1'b0;
    set_mode  = 1'b0;
    set_field = 2'b11;
    set_inc   = 1'b0;
    set_dec   = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_sec", sec, 0);
    chk("rst_min", min, 0);
    chk("rst_hour", hour, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dc", day_carry, 0);
    chk("rst_ovr", tick_overrun, 0);
    chk("rst_alu_s", alu_s, 0);
    chk("rst_alu_cin", alu_cin, 0);

    // Set 00:00:05 with increments
    set_mode  = 1'b1;
    set_field = 2'b00;
    set_inc   = 1'b1;
    step();
    set_inc = 1'b0;
    chk("ed_busy", busy, 1);
    chk("ed_alu_s", alu_s, 2);
    chk("ed_alu_cin", alu_cin, 1);
    step();
    chk("ed_sec1", sec, 1);
    chk("ed_idle", busy, 0);
    for (int i = 0; i < 4; i++) edit(2'b00, 1'b1, 1'b0);
    chk("ed_sec5", sec, 5);

    // Tick latency: two edges
    set_mode = 1'b0;
    tick_once();
    chk("tk_busy", busy, 1);
    chk("tk_alu_s", alu_s, 2);
    chk("tk_alu_a", alu_a, 5);
    chk("tk_alu_cin", alu_cin, 1);
    step();
    chk("tk_sec6", sec, 6);
    chk("tk_idle", busy, 0);
    chk("tk_alu_s0", alu_s, 0);

    // Three consecutive ticks
    tick_1hz = 1'b1;
    step();
    chk("t3_a_busy", busy, 1);
    step();
    chk("t3_b_sec", sec, 7);
    chk("t3_b_ovr", tick_overrun, 0);
    step();
    tick_1hz = 1'b0;
    chk("t3_c_busy", busy, 1);
    chk("t3_c_ovr", tick_overrun, 1);
    step();
    chk("t3_d_sec", sec, 8);
    step();
    chk("t3_sticky", tick_overrun, 1);
    chk("t3_sec_hold", sec, 8);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_ovr", tick_overrun, 0);
    chk("rst2_sec", sec, 0);

    // Ticks ignored in set mode
    set_mode = 1'b1;
    tick_once();
    chk("sm_busy", busy, 0);
    set_mode = 1'b0;
    step();
    step();
    chk("sm_sec", sec, 0);
    chk("sm_ovr", tick_overrun, 0);

    // Hour edit wrap both ways
    set_mode = 1'b1;
    edit(2'b10, 1'b0, 1'b1);
    chk("hr_dec", hour, 23);
    chk("hr_dec_dc", day_carry, 0);
    edit(2'b10, 1'b1, 1'b0);
    chk("hr_inc", hour, 0);
    chk("hr_inc_dc", day_carry, 0);
    edit(2'b10, 1'b0, 1'b1);
    edit(2'b01, 1'b0, 1'b1);
    edit(2'b00, 1'b0, 1'b1);
    chk("set_sec59", sec, 59);
    chk("set_min59", min, 59);
    chk("set_hr23", hour, 23);
    edit(2'b00, 1'b0, 1'b1);
    chk("dec_58", sec, 58);
    edit(2'b00, 1'b1, 1'b0);
    chk("inc_59", sec, 59);

    // Illegal edit requests
    set_field = 2'b00;
    set_inc   = 1'b1;
    set_dec   = 1'b1;
    step();
    chk("both_busy", busy, 0);
    set_dec = 1'b0;
    set_field = 2'b11;
    step();
    set_inc = 1'b0;
    chk("none_busy", busy, 0);
    step();
    chk("ill_sec", sec, 59);

    // Full day cascade
    set_mode = 1'b0;
    tick_once();
    chk("cas1_busy", busy, 1);
    step();
    chk("cas2_sec", sec, 0);
    chk("cas2_alu_a", alu_a, 59);
    chk("cas2_min", min, 59);
    step();
    chk("cas3_min", min, 0);
    chk("cas3_hour", hour, 23);
    chk("cas3_alu_a", alu_a, 23);
    step();
    chk("cas4_hour", hour, 0);
    chk("cas4_dc", day_carry, 1);
    chk("cas4_busy", busy, 0);
    step();
    chk("cas5_dc", day_carry, 0);

    // Reset in MIN during 00:59:59 cascade
    set_mode = 1'b1;
    edit(2'b00, 1'b0, 1'b1);
    edit(2'b01, 1'b0, 1'b1);
    set_mode = 1'b0;
    tick_once();
    step();
    chk("mr_min_state", alu_a, 59);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_sec", sec, 0);
    chk("mr_min", min, 0);
    chk("mr_hour", hour, 0);
    chk("mr_busy", busy, 0);
    chk("mr_alu_a", alu_a, 0);
    chk("mr_alu_s", alu_s, 0);
    step();
    chk("mr_hold_min", min, 0);
    tick_once();
    step();
    chk("mr_tick_sec", sec, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
